// File: rtl/jaa_sequencer_if.sv
// Byte-in / word-out handshake bundle for jaa_sequencer.
// master = bytecode source + word sink side, slave = the sequencer.
interface jaa_sequencer_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;

   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data);
endinterface

// File: rtl/jaa_sequencer.sv
// JVM bytecode -> ARM macro-expansion sequencer (opcode fetch, operand fetch, word emission).
// Optional: define JAA_SIPUSH_EN to support sipush (0x11); otherwise 0x11 is unsupported.
module jaa_sequencer #(
   parameter logic [3:0] FRAME_REG = 4'd3,
   parameter int         CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   jaa_sequencer_if.slave   bus,
   output logic             unsupported,
   output logic             busy,
   output logic [CNT_W-1:0] words_out
);

   localparam logic [31:0] PUSH = 32'hE92D0002;
   localparam logic [31:0] POP1 = 32'hE8BD0002;
   localparam logic [31:0] POP2 = 32'hE8BD0006;

   typedef enum logic [1:0] {OPCODE, OPERAND1, OPERAND2, EMIT} state_t;

   typedef struct packed {
      logic       ok;
      logic [1:0] nops;
      logic [1:0] last;   // index of the final word of the expansion
   } dec_t;

   function automatic dec_t decode(input logic [7:0] op);
      decode = '{ok: 1'b0, nops: 2'd0, last: 2'd0};
      case (op)
         8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
         8'h1A, 8'h1B, 8'h1C, 8'h1D,
         8'h3B, 8'h3C, 8'h3D, 8'h3E: decode = '{ok: 1'b1, nops: 2'd0, last: 2'd1};
         8'h10, 8'h15, 8'h36:        decode = '{ok: 1'b1, nops: 2'd1, last: 2'd1};
         8'h59, 8'h60, 8'h64:        decode = '{ok: 1'b1, nops: 2'd0, last: 2'd2};
`ifdef JAA_SIPUSH_EN
         8'h11:                      decode = '{ok: 1'b1, nops: 2'd2, last: 2'd3};
`endif
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] word_of(input logic [7:0] op, input logic [15:0] v,
                                           input logic [1:0] k);
      logic [7:0]  n;
      logic [1:0]  idx;
      logic [11:0] off;
      logic [31:0] fr;
      n   = op - 8'h03;
      // _0.._3 short forms: bit 5 separates istore_n (0x3B..) from iload_n (0x1A..)
      idx = op[1:0] + (op[5] ? 2'd1 : 2'd2);
      off = (op == 8'h15 || op == 8'h36) ? {2'b00, v[7:0], 2'b00} : {8'd0, idx, 2'b00};
      fr  = {12'd0, FRAME_REG, 16'd0};
      word_of = PUSH;
      case (op)
         8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08:
            if (k == 2'd0) word_of = 32'hE3A01000 | {24'd0, n};
         8'h10:
            if (k == 2'd0) word_of = v[7] ? (32'hE3E01000 | {24'd0, ~v[7:0]})
                                          : (32'hE3A01000 | {24'd0, v[7:0]});
         8'h15, 8'h1A, 8'h1B, 8'h1C, 8'h1D:
            if (k == 2'd0) word_of = 32'hE5901000 | fr | {20'd0, off};
         8'h36, 8'h3B, 8'h3C, 8'h3D, 8'h3E:
            word_of = (k == 2'd0) ? POP1 : (32'hE5801000 | fr | {20'd0, off});
         8'h60:
            if (k == 2'd0) word_of = POP2; else if (k == 2'd1) word_of = 32'hE0811002;
         8'h64:
            if (k == 2'd0) word_of = POP2; else if (k == 2'd1) word_of = 32'hE0421001;
         8'h59:
            if (k == 2'd0) word_of = POP1;
         8'h11:
            case (k)
               2'd0:    word_of = 32'hE3001000 | {12'd0, v[15:12], 16'd0} | {20'd0, v[11:0]};
               2'd1:    word_of = 32'hE1A01801;
               2'd2:    word_of = 32'hE1A01841;
               default: word_of = PUSH;
            endcase
         default: ;
      endcase
   endfunction

   state_t      state, state_d;
   logic [7:0]  op_q, ld_op;
   logic [15:0] opr_q, ld_opr;
   logic [1:0]  k_q;
   logic        acc, hs, load, adv, unsup_d;
   dec_t        din, dq;

   assign bus.in_ready = (state != EMIT) && !reset;
   assign busy         = (state != OPCODE);
   assign acc          = bus.in_valid && bus.in_ready;
   assign hs           = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= OPCODE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      ld_op   = op_q;
      ld_opr  = opr_q;
      load    = 1'b0;
      adv     = 1'b0;
      unsup_d = 1'b0;
      din     = decode(bus.in_data);
      dq      = decode(op_q);
      case (state)
         OPCODE:
            if (acc) begin
               if (!din.ok) unsup_d = 1'b1;
               else begin
                  ld_op  = bus.in_data;
                  ld_opr = 16'd0;
                  if (din.nops == 2'd0) begin
                     state_d = EMIT;
                     load    = 1'b1;
                  end else state_d = OPERAND1;
               end
            end
         OPERAND1:
            if (acc) begin
               if (dq.nops == 2'd2) begin
                  ld_opr  = {bus.in_data, 8'd0};
                  state_d = OPERAND2;
               end else begin
                  ld_opr  = {8'd0, bus.in_data};
                  state_d = EMIT;
                  load    = 1'b1;
               end
            end
         OPERAND2:
            if (acc) begin
               ld_opr  = {opr_q[15:8], bus.in_data};
               state_d = EMIT;
               load    = 1'b1;
            end
         EMIT:
            if (hs) begin
               if (k_q == dq.last || !dq.ok) state_d = OPCODE;
               else                           adv     = 1'b1;
            end
         default: state_d = OPCODE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q          <= 8'd0;
         opr_q         <= 16'd0;
         k_q           <= 2'd0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= 32'd0;
         unsupported   <= 1'b0;
         words_out     <= '0;
      end else begin
         op_q        <= ld_op;
         opr_q       <= ld_opr;
         unsupported <= unsup_d;
         if (hs) words_out <= words_out + 1'b1;
         if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= word_of(ld_op, ld_opr, 2'd0);
            k_q           <= 2'd0;
         end else if (hs) begin
            if (adv) begin
               k_q          <= k_q + 2'd1;
               bus.out_data <= word_of(op_q, opr_q, k_q + 2'd1);
            end else bus.out_valid <= 1'b0;
         end
      end
   end

endmodule
